fft_accel_top: RTL and testbench

Radix-2 in-place FFT accelerator with register control and a sample-memory port. The host loads N complex Q1.15 samples over the memory port, starts the transform through a control register, and reads back natural-order frequency bins from the same port. Status is exported as level outputs for interrupt wiring.

---
 rtl/fft_pkg.sv | 45 ++++
 rtl/fft_butterfly.sv | 57 +++++
 rtl/fft_accel_top.sv | 188 ++++++++++++++++++
 tb/tb_fft_accel_top.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT accelerator.
//   cplx_t   : packed complex sample, {im, re}, both signed Q1.15
//   *_OFF    : APB register byte offsets
//   ST_*     : STATUS register bit positions
//   state_t  : control FSM states
//   twiddle(): W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) in Q1.15, evaluated at elaboration
package fft_pkg;

  typedef struct packed {
    logic signed [15:0] im;
    logic signed [15:0] re;
  } cplx_t;

  localparam logic [15:0] CTRL_OFF   = 16'h0000;
  localparam logic [15:0] STATUS_OFF = 16'h0004;
  localparam logic [15:0] INFO_OFF   = 16'h0008;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_DONE  = 1;
  localparam int unsigned ST_ERROR = 2;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam real PI = 3.14159265358979323846;

  // Rounded to nearest; +1.0 saturates to 32767, -1.0 encodes as -32768.
  function automatic cplx_t twiddle(input int unsigned k, input int unsigned log2n);
    real   ang;
    int    ci;
    int    si;
    cplx_t w;
    ang = 2.0 * PI * real'(k) / real'(1 << log2n);
    ci  = int'($cos(ang) * 32768.0);
    si  = int'(-$sin(ang) * 32768.0);
    if (ci > 32767) ci = 32767;
    if (si > 32767) si = 32767;
    w.re = 16'(ci);
    w.im = 16'(si);
    return w;
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 butterfly with scaling.
//   a_i, b_i : input pair (Q1.15 complex)
//   k_i      : twiddle index, 0..N/2-1
//   a_o      : (A + B*W^k) >>> 1
//   b_o      : (A - B*W^k) >>> 1
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = 4
) (
  input  cplx_t            a_i,
  input  cplx_t            b_i,
  input  logic [LOG2N-2:0] k_i,
  output cplx_t            a_o,
  output cplx_t            b_o
);

  localparam int HALFN = 1 << (LOG2N - 1);

  cplx_t rom [HALFN];

  for (genvar g = 0; g < HALFN; g++) begin : g_rom
    assign rom[g] = twiddle(g, LOG2N);
  end

  cplx_t              w;
  cplx_t              t;
  logic signed [32:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [32:0] acc_re, acc_im;
  logic signed [16:0] s_re, s_im, d_re, d_im;

  always_comb begin
    w      = rom[k_i];
    p_rr   = 33'(b_i.re) * 33'(w.re);
    p_ii   = 33'(b_i.im) * 33'(w.im);
    p_ri   = 33'(b_i.re) * 33'(w.im);
    p_ir   = 33'(b_i.im) * 33'(w.re);
    acc_re = p_rr - p_ii;
    acc_im = p_ri + p_ir;
    // W^0 is stored as 32767, not 1.0, so k=0 must skip the multiplier to stay exact.
    if (k_i == '0) begin
      t = b_i;
    end else begin
      t.re = 16'(acc_re >>> 15);
      t.im = 16'(acc_im >>> 15);
    end
    s_re   = 17'(a_i.re) + 17'(t.re);
    s_im   = 17'(a_i.im) + 17'(t.im);
    d_re   = 17'(a_i.re) - 17'(t.re);
    d_im   = 17'(a_i.im) - 17'(t.im);
    a_o.re = 16'(s_re >>> 1);
    a_o.im = 16'(s_im >>> 1);
    b_o.re = 16'(d_re >>> 1);
    b_o.im = 16'(d_im >>> 1);
  end

endmodule

// File: rtl/fft_accel_top.sv
// Radix-2 in-place FFT accelerator.
//   clk_i, reset_n_i          : clock, synchronous active-low reset
//   psel_i..pready_o          : APB control (CTRL 0x00, STATUS 0x04, INFO 0x08)
//   axi_aw*/axi_w*            : sample writes, stored bit-reversed
//   axi_ar*/axi_r*            : sample reads, natural bin order
//   fft_done_o, fft_error_o   : STATUS.DONE / STATUS.ERROR levels
module fft_accel_top
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [15:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  input  logic [31:0] axi_awaddr_i,
  input  logic        axi_awvalid_i,
  output logic        axi_awready_o,
  input  logic [63:0] axi_wdata_i,
  input  logic        axi_wvalid_i,
  output logic        axi_wready_o,
  input  logic [31:0] axi_araddr_i,
  input  logic        axi_arvalid_i,
  output logic        axi_arready_o,
  output logic [63:0] axi_rdata_o,
  output logic        axi_rvalid_o,
  input  logic        axi_rready_i,
  output logic        fft_done_o,
  output logic        fft_error_o
);

  localparam int unsigned N          = 1 << LOG2N;
  localparam logic [3:0]  LAST_STAGE = 4'(LOG2N - 1);

  typedef logic [LOG2N-1:0] idx_t;
  typedef logic [LOG2N-2:0] kidx_t;

  state_t      state_q, state_d;
  cplx_t       mem_q [N];
  kidx_t       j_q;
  logic [3:0]  stage_q;
  logic        done_q, err_q;
  logic [31:0] prdata_q;
  logic [63:0] rdata_q;
  logic        rvalid_q;

  logic  busy, last_bfly;
  logic  apb_wr, apb_rd_setup, start_wr, start_idle, sts_wr;
  logic  aw_hs, ar_hs, err_set;
  idx_t  wr_idx, rd_idx;
  idx_t  jx, half, hmask, idx_a, idx_b;
  kidx_t tw_k;
  cplx_t bf_a, bf_b;

  function automatic idx_t bitrev(input idx_t v);
    idx_t r;
    for (int unsigned i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Bus decode
  assign apb_wr       = psel_i & penable_i & pwrite_i;
  assign apb_rd_setup = psel_i & ~penable_i & ~pwrite_i;
  assign start_wr     = apb_wr & (paddr_i == CTRL_OFF) & pwdata_i[0];
  assign sts_wr       = apb_wr & (paddr_i == STATUS_OFF);
  assign start_idle   = start_wr & ~busy;
  assign aw_hs        = axi_awvalid_i & axi_wvalid_i;
  assign ar_hs        = axi_arvalid_i & ~rvalid_q;
  assign err_set      = busy & (start_wr | aw_hs | ar_hs);
  assign wr_idx       = axi_awaddr_i[LOG2N+2:3];
  assign rd_idx       = axi_araddr_i[LOG2N+2:3];

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_wr) state_d = S_RUN;
      S_RUN:   if (last_bfly) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q == S_RUN);
    last_bfly = busy & (&j_q) & (stage_q == LAST_STAGE);
  end

  // Butterfly addressing for stage s = stage_q, butterfly j = j_q
  always_comb begin
    jx    = idx_t'(j_q);
    half  = idx_t'(1 << stage_q);
    hmask = half - 1'b1;
    idx_a = ((jx >> stage_q) << (stage_q + 4'd1)) | (jx & hmask);
    idx_b = idx_a + half;
    tw_k  = kidx_t'((jx & hmask) << (4'(LOG2N - 1) - stage_q));
  end

  fft_butterfly #(
    .LOG2N(LOG2N)
  ) u_bfly (
    .a_i(mem_q[idx_a]),
    .b_i(mem_q[idx_b]),
    .k_i(tw_k),
    .a_o(bf_a),
    .b_o(bf_b)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < N; i++) mem_q[i] <= '0;
      j_q      <= '0;
      stage_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      // Memory: butterflies own it while running; host writes are dropped then.
      if (busy) begin
        mem_q[idx_a] <= bf_a;
        mem_q[idx_b] <= bf_b;
      end else if (aw_hs) begin
        mem_q[bitrev(wr_idx)] <= axi_wdata_i[31:0];
      end

      // j wraps naturally at N/2; stage wraps after the last one.
      if (start_idle) begin
        j_q     <= '0;
        stage_q <= '0;
      end else if (busy) begin
        j_q <= j_q + 1'b1;
        if (&j_q) stage_q <= (stage_q == LAST_STAGE) ? 4'd0 : stage_q + 4'd1;
      end

      // START beats a same-write DONE clear; completion beats a same-cycle clear.
      if (start_idle)                       done_q <= 1'b0;
      else if (last_bfly)                   done_q <= 1'b1;
      else if (sts_wr && pwdata_i[ST_DONE]) done_q <= 1'b0;

      if (err_set)                           err_q <= 1'b1;
      else if (sts_wr && pwdata_i[ST_ERROR]) err_q <= 1'b0;

      if (apb_rd_setup) begin
        case (paddr_i)
          STATUS_OFF: prdata_q <= {29'b0, err_q, done_q, busy};
          INFO_OFF:   prdata_q <= 32'(LOG2N);
          default:    prdata_q <= '0;
        endcase
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= busy ? 64'b0 : {32'b0, mem_q[rd_idx]};
      end else if (rvalid_q && axi_rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign prdata_o      = prdata_q;
  assign pready_o      = 1'b1;
  assign axi_awready_o = aw_hs;
  assign axi_wready_o  = aw_hs;
  assign axi_arready_o = ~rvalid_q;
  assign axi_rdata_o   = rdata_q;
  assign axi_rvalid_o  = rvalid_q;
  assign fft_done_o    = done_q;
  assign fft_error_o   = err_q;

  logic unused_inputs;
  assign unused_inputs = ^{axi_awaddr_i[31:LOG2N+3], axi_awaddr_i[2:0],
                           axi_araddr_i[31:LOG2N+3], axi_araddr_i[2:0],
                           axi_wdata_i[63:32], pwdata_i[31:3]};

endmodule

// File: tb/tb_fft_accel_top.sv
module tb_fft_accel_top;

  localparam int LOG2N   = 4;
  localparam int N       = 1 << LOG2N;
  localparam int LATENCY = 1 + LOG2N * N / 2;
  localparam real PI     = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic        wvalid, wready;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic        rvalid, rready;
  logic        done_o, error_o;

  fft_accel_top #(.LOG2N(LOG2N)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
    .axi_awaddr_i(awaddr), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_araddr_i(araddr), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rdata_o(rdata), .axi_rvalid_o(rvalid), .axi_rready_i(rready),
    .fft_done_o(done_o), .fft_error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int re;
    int im;
    int tol;
  } exp_t;

  exp_t sbq[$];
  int   xin[N];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [63:0] obs,
                         input int ere, input int eim, input int tol);
    int   dr, di;
    logic ok;
    dr = int'(signed'(obs[15:0])) - ere;
    di = int'(signed'(obs[31:16])) - eim;
    ok = (dr <= tol) && (dr >= -tol) && (di <= tol) && (di >= -tol) && (obs[63:32] == 32'h0);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s: observed re=%0d im=%0d hi=%h expected re=%0d im=%0d tol=%0d",
             tag, int'(signed'(obs[15:0])), int'(signed'(obs[31:16])), obs[63:32], ere, eim, tol);
    end
  endtask

  // Golden scaled DFT of the real input vector: X[k]/N.
  function automatic void dft_bin(input int k, output int re, output int im);
    real sr, si, ang;
    sr = 0.0;
    si = 0.0;
    for (int n = 0; n < N; n++) begin
      ang = 2.0 * PI * real'(k * n) / real'(N);
      sr  = sr + real'(xin[n]) * $cos(ang);
      si  = si - real'(xin[n]) * $sin(ang);
    end
    re = int'(sr / real'(N));
    im = int'(si / real'(N));
  endfunction

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    d = prdata;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Upper address bits are set to show they wrap away.
  task automatic axi_write(input int idx, input int re);
    @(negedge clk);
    awaddr  = 32'h0000_0400 | (32'(idx) << 3);
    wdata   = {32'hDEAD_BEEF, 16'h0000, 16'(re)};
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic load_samples();
    for (int n = 0; n < N; n++) axi_write(n, xin[n]);
  endtask

  // Pops the expectation pushed for this read when the data arrives.
  task automatic issue_read(input int idx);
    exp_t e;
    int   n;
    @(negedge clk);
    araddr  = 32'h0000_0800 | (32'(idx) << 3);
    arvalid = 1'b1;
    rready  = 1'b1;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("rvalid%0d", idx), 64'(rvalid), 64'd1);
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'(sbq.size()), 64'd1);
    end else begin
      e = sbq.pop_front();
      if (e.tol == 0)
        chk($sformatf("bin%0d", e.idx), rdata, {32'h0, 16'(e.im), 16'(e.re)});
      else
        chk_tol($sformatf("bin%0d", e.idx), rdata, e.re, e.im, e.tol);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_bins(input int tol, input bit zero);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.idx = k;
      e.tol = tol;
      if (zero) begin
        e.re = 0;
        e.im = 0;
      end else begin
        dft_bin(k, e.re, e.im);
      end
      sbq.push_back(e);
      issue_read(k);
    end
  endtask

  // n counts the START edge itself plus every edge until done is seen.
  task automatic wait_done(output int n);
    n = 1;
    while (!done_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_timeout", 64'(done_o), 64'd1);
  endtask

  initial begin
    logic [31:0] d;
    int          lat;

    reset_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", 64'(prdata), 64'h0);
    chk("rst_pready", 64'(pready), 64'h1);
    chk("rst_awready", 64'(awready), 64'h0);
    chk("rst_wready", 64'(wready), 64'h0);
    chk("rst_arready", 64'(arready), 64'h1);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    chk("rst_done", 64'(done_o), 64'h0);
    chk("rst_error", 64'(error_o), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Registers and handshake boundaries
    apb_read(16'h0008, d); chk("info", 64'(d), 64'd4);
    apb_read(16'h0004, d); chk("status_rst", 64'(d), 64'h0);
    apb_read(16'h0000, d); chk("ctrl_read", 64'(d), 64'h0);
    apb_read(16'h000C, d); chk("unmapped", 64'(d), 64'h0);
    @(negedge clk);
    awvalid = 1'b1;
    #1 chk("lone_awvalid", 64'(awready), 64'h0);
    wvalid = 1'b1;
    #1 chk("aw_w_both", 64'({awready, wready}), 64'h3);
    awvalid = 1'b0;
    wvalid  = 1'b0;

    // Impulse
    for (int n = 0; n < N; n++) xin[n] = 0;
    xin[0] = 16384;
    load_samples();
    apb_write(16'h0000, 32'h1);
    wait_done(lat);
    chk("latency", 64'(lat), 64'(LATENCY));
    apb_read(16'h0004, d); chk("status_done", 64'(d), 64'h2);
    read_bins(0, 1'b0);
    apb_write(16'h0004, 32'h2);
    apb_read(16'h0004, d); chk("done_w1c", 64'(d), 64'h0);
    chk("done_o_w1c", 64'(done_o), 64'h0);

    // DC
    for (int n = 0; n < N; n++) xin[n] = 16384;
    load_samples();
    apb_write(16'h0000, 32'h1);
    wait_done(lat);
    read_bins(0, 1'b0);

    // Tone: four truncating stages can each bias the result by about one LSB.
    for (int n = 0; n < N; n++) xin[n] = int'(16384.0 * $cos(2.0 * PI * real'(n) / real'(N)));
    load_samples();
    apb_write(16'h0000, 32'h1);
    wait_done(lat);
    read_bins(4, 1'b0);

    // Error sources while running
    for (int n = 0; n < N; n++) xin[n] = 0;
    xin[0] = 16384;
    load_samples();
    apb_write(16'h0000, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    apb_write(16'h0000, 32'h1);
    axi_write(0, 32767);
    begin
      exp_t e;
      e.idx = 1; e.re = 0; e.im = 0; e.tol = 0;
      sbq.push_back(e);
      issue_read(1);
    end
    chk("error_o_set", 64'(error_o), 64'h1);
    wait_done(lat);
    apb_read(16'h0004, d); chk("status_err", 64'(d), 64'h6);
    read_bins(0, 1'b0);
    apb_write(16'h0004, 32'h4);
    apb_read(16'h0004, d); chk("err_w1c", 64'(d), 64'h2);
    chk("error_o_clr", 64'(error_o), 64'h0);

    // Reset mid-run
    for (int n = 0; n < N; n++) xin[n] = 16384;
    load_samples();
    apb_write(16'h0000, 32'h1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    apb_read(16'h0004, d); chk("status_midrst", 64'(d), 64'h0);
    chk("done_o_midrst", 64'(done_o), 64'h0);
    read_bins(0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
